// File: rtl/axi_ram_if_mem_if.sv
// Command/response bundle between an AXI front end and the RAM back end.
// The master drives commands and accepts read beats; the slave owns the storage.
interface axi_ram_if_mem_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned RUSER_WIDTH = 1
) ();
  logic [ID_WIDTH-1:0]    ram_cmd_id;
  logic [ADDR_WIDTH-1:0]  ram_cmd_addr;
  logic [DATA_WIDTH-1:0]  ram_cmd_wr_data;
  logic [STRB_WIDTH-1:0]  ram_cmd_wr_strb;
  logic                   ram_cmd_wr_en;
  logic                   ram_cmd_rd_en;
  logic                   ram_cmd_last;
  logic                   ram_cmd_ready;

  logic [ID_WIDTH-1:0]    ram_rd_resp_id;
  logic [DATA_WIDTH-1:0]  ram_rd_resp_data;
  logic                   ram_rd_resp_last;
  logic [RUSER_WIDTH-1:0] ram_rd_resp_user;
  logic                   ram_rd_resp_valid;
  logic                   ram_rd_resp_ready;

  modport slave (
    input  ram_cmd_id, ram_cmd_addr, ram_cmd_wr_data, ram_cmd_wr_strb,
           ram_cmd_wr_en, ram_cmd_rd_en, ram_cmd_last, ram_rd_resp_ready,
    output ram_cmd_ready, ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
           ram_rd_resp_user, ram_rd_resp_valid
  );

  modport master (
    output ram_cmd_id, ram_cmd_addr, ram_cmd_wr_data, ram_cmd_wr_strb,
           ram_cmd_wr_en, ram_cmd_rd_en, ram_cmd_last, ram_rd_resp_ready,
    input  ram_cmd_ready, ram_rd_resp_id, ram_rd_resp_data, ram_rd_resp_last,
           ram_rd_resp_user, ram_rd_resp_valid
  );
endinterface

// File: rtl/axi_ram_if_mem.sv
// Byte-enabled RAM with a small in-order read response FIFO and credit-based command ready.
// Define AXI_RAM_IF_MEM_OUT_REG_EN to add a read output register (latency 2, FIFO depth 3).
module axi_ram_if_mem #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned RUSER_WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_ram_if_mem_if.slave  bus
);
  localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned WORDS    = 2 ** IDX_W;
`ifdef AXI_RAM_IF_MEM_OUT_REG_EN
  localparam int unsigned DEPTH    = 3;
`else
  localparam int unsigned DEPTH    = 2;
`endif
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  logic [DATA_WIDTH-1:0] mem [WORDS];
  beat_t                 fifo_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, occ;
  logic [IDX_W-1:0]      word_idx;
  logic                  wr_fire, rd_fire, push, pop;
  beat_t                 rd_beat, push_beat, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign word_idx = bus.ram_cmd_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_fire  = bus.ram_cmd_wr_en & bus.ram_cmd_ready;
  assign rd_fire  = bus.ram_cmd_rd_en & bus.ram_cmd_ready & ~bus.ram_cmd_wr_en;
  assign rd_beat  = {bus.ram_cmd_id, mem[word_idx], bus.ram_cmd_last};
  assign pop      = bus.ram_rd_resp_valid & bus.ram_rd_resp_ready;

  // Storage is never reset; only enabled byte lanes change.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
        if (bus.ram_cmd_wr_strb[i]) mem[word_idx][i*8 +: 8] <= bus.ram_cmd_wr_data[i*8 +: 8];
      end
    end
  end

`ifdef AXI_RAM_IF_MEM_OUT_REG_EN
  logic  stage_valid_q;
  beat_t stage_q;

  // Output register between the RAM read and the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_q       <= '0;
    end else begin
      stage_valid_q <= rd_fire;
      if (rd_fire) stage_q <= rd_beat;
    end
  end

  assign push      = stage_valid_q;
  assign push_beat = stage_q;
  assign occ       = count_q + CNT_W'(stage_valid_q);
`else
  assign push      = rd_fire;
  assign push_beat = rd_beat;
  assign occ       = count_q;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_beat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Accept only when every beat already in flight is guaranteed a FIFO slot.
  assign bus.ram_cmd_ready = rst_n & (occ < CNT_W'(DEPTH));

  assign head                  = fifo_q[rd_ptr_q];
  assign bus.ram_rd_resp_valid = (count_q != '0);
  assign bus.ram_rd_resp_id    = bus.ram_rd_resp_valid ? head.id   : '0;
  assign bus.ram_rd_resp_data  = bus.ram_rd_resp_valid ? head.data : '0;
  assign bus.ram_rd_resp_last  = bus.ram_rd_resp_valid & head.last;
  assign bus.ram_rd_resp_user  = '0;
endmodule

// File: tb/tb_axi_ram_if_mem.sv
// Scoreboard bench for axi_ram_if_mem: a word-array model predicts read beats at issue time,
// and an independent monitor compares every beat the DUT hands over.
module tb_axi_ram_if_mem;
  localparam int unsigned DW = 32, AW = 16, SW = 4, IW = 8, UW = 1;
`ifdef AXI_RAM_IF_MEM_OUT_REG_EN
  localparam int LAT = 2, DEPTH = 3;
`else
  localparam int LAT = 1, DEPTH = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_ram_if_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
                      .ID_WIDTH(IW), .RUSER_WIDTH(UW)) bus ();

  axi_ram_if_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
                   .ID_WIDTH(IW), .RUSER_WIDTH(UW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mdl [64];
  int n_checks = 0, n_pass = 0, rr_mode = 1, stalls = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Response-ready driver: 0 = stall, 1 = always ready, otherwise random.
  initial begin
    bus.ram_rd_resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       bus.ram_rd_resp_ready = 1'b0;
        1:       bus.ram_rd_resp_ready = 1'b1;
        default: bus.ram_rd_resp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each handshaken beat with the scoreboard; stalled heads must hold.
  initial begin
    exp_t e, hold;
    bit   have_hold;
    have_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.ram_rd_resp_valid) have_hold = 1'b0;
      else begin
        if (have_hold) begin
          chk("held_id",   64'(bus.ram_rd_resp_id),   64'(hold.id));
          chk("held_data", 64'(bus.ram_rd_resp_data), 64'(hold.data));
        end
        if (bus.ram_rd_resp_ready) begin
          have_hold = 1'b0;
          chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("resp_id",   64'(bus.ram_rd_resp_id),   64'(e.id));
            chk("resp_data", 64'(bus.ram_rd_resp_data), 64'(e.data));
            chk("resp_last", 64'(bus.ram_rd_resp_last), 64'(e.last));
            chk("resp_user", 64'(bus.ram_rd_resp_user), 64'd0);
          end
        end else begin
          have_hold = 1'b1;
          hold.id   = bus.ram_rd_resp_id;
          hold.data = bus.ram_rd_resp_data;
        end
      end
    end
  end

  // Present one command, wait for acceptance, update the model at the accepting edge.
  task automatic issue(input bit wr, input bit rd, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [7:0] id, input bit last);
    int waitc, idx;
    bit ok;
    exp_t e;
    waitc = 0; ok = 1'b1;
    bus.ram_cmd_wr_en = wr; bus.ram_cmd_rd_en = rd; bus.ram_cmd_addr = addr;
    bus.ram_cmd_wr_data = data; bus.ram_cmd_wr_strb = strb; bus.ram_cmd_id = id;
    bus.ram_cmd_last = last;
    @(negedge clk);
    while (!bus.ram_cmd_ready) begin
      waitc++;
      if (waitc > 100) begin
        chk("cmd_ready_timeout", 64'(bus.ram_cmd_ready), 64'd1);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
    end
    stalls += waitc;
    if (ok) begin
      idx = int'(addr[7:2]);
      if (wr) begin
        for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
      end else if (rd) begin
        e.id = id; e.data = mdl[idx]; e.last = last;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #2;
    bus.ram_cmd_wr_en = 1'b0;
    bus.ram_cmd_rd_en = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    rr_mode = 1;
    while (exp_q.size() != 0 && c < 200) begin @(negedge clk); c++; end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #2;
  endtask

  // Read from an empty pipe: check latency and the returned beat directly.
  task automatic read_direct(input logic [15:0] addr, input logic [7:0] id, input bit last,
                             input logic [31:0] want);
    issue(1'b0, 1'b1, addr, 32'h0, 4'h0, id, last);
    for (int c = 1; c <= LAT; c++) begin
      if (c > 1) @(negedge clk);
      else @(negedge clk);
      chk("rd_valid_latency", 64'(bus.ram_rd_resp_valid), 64'(c == LAT));
    end
    chk("rd_direct_data", 64'(bus.ram_rd_resp_data), 64'(want));
    chk("rd_direct_id",   64'(bus.ram_rd_resp_id),   64'(id));
    chk("rd_direct_last", 64'(bus.ram_rd_resp_last), 64'(last));
    drain();
  endtask

  initial begin
    bus.ram_cmd_wr_en = 1'b0; bus.ram_cmd_rd_en = 1'b0; bus.ram_cmd_addr = '0;
    bus.ram_cmd_wr_data = '0; bus.ram_cmd_wr_strb = '0; bus.ram_cmd_id = '0;
    bus.ram_cmd_last = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cmd_ready",  64'(bus.ram_cmd_ready),     64'd0);
    chk("rst_resp_valid", 64'(bus.ram_rd_resp_valid), 64'd0);
    chk("rst_resp_id",    64'(bus.ram_rd_resp_id),    64'd0);
    chk("rst_resp_data",  64'(bus.ram_rd_resp_data),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_reset", 64'(bus.ram_cmd_ready), 64'd1);
    @(posedge clk); #2;

    for (int i = 0; i < 64; i++) issue(1'b1, 1'b0, 16'(i * 4), $urandom, 4'hF, 8'h0, 1'b0);

    // Basic write then read with latency check.
    issue(1'b1, 1'b0, 16'h0010, 32'hA5A5A5A5, 4'hF, 8'h0, 1'b0);
    read_direct(16'h0010, 8'h03, 1'b1, 32'hA5A5A5A5);

    // Partial byte-lane update.
    issue(1'b1, 1'b0, 16'h0020, 32'h11223344, 4'hF, 8'h0, 1'b0);
    issue(1'b1, 1'b0, 16'h0020, 32'hFFFFFFFF, 4'h5, 8'h0, 1'b0);
    read_direct(16'h0022, 8'h07, 1'b0, 32'h11FF33FF);

    // Backpressure: FIFO fills, command ready drops, head held, in-order release.
    rr_mode = 0;
    @(posedge clk); #2;
    for (int i = 1; i <= DEPTH; i++) issue(1'b0, 1'b1, 16'(i * 4), 32'h0, 4'h0, 8'(i), 1'b0);
    @(negedge clk);
    chk("ready_when_full", 64'(bus.ram_cmd_ready), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid",   64'(bus.ram_rd_resp_valid), 64'd1);
      chk("stall_head_id", 64'(bus.ram_rd_resp_id),    64'd1);
    end
    rr_mode = 1;
    issue(1'b0, 1'b1, 16'h0030, 32'h0, 4'h0, 8'(DEPTH + 1), 1'b1);
    drain();
    chk("ready_returns", 64'(bus.ram_cmd_ready), 64'd1);

    // Simultaneous write and read: write wins, no beat.
    issue(1'b1, 1'b1, 16'h0040, 32'h00000005, 4'hF, 8'h09, 1'b1);
    repeat (4) @(negedge clk);
    chk("wr_rd_no_beat", 64'(bus.ram_rd_resp_valid), 64'd0);
    @(posedge clk); #2;
    read_direct(16'h0040, 8'h0A, 1'b1, 32'h00000005);

    // Back-to-back reads at full throughput.
    stalls = 0;
    for (int i = 0; i < 20; i++)
      issue(1'b0, 1'b1, 16'($urandom_range(0, 255)), 32'h0, 4'h0, 8'($urandom), 1'($urandom));
    chk("throughput_stalls", 64'(stalls), 64'd0);
    drain();

    // Random mix with random response backpressure.
    rr_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin @(posedge clk); #2; end
        1: issue(1'b1, 1'b0, 16'($urandom_range(0, 255)), $urandom, 4'($urandom), 8'h0, 1'b0);
        2: issue(1'b0, 1'b1, 16'($urandom_range(0, 255)), 32'h0, 4'h0, 8'($urandom), 1'($urandom));
        default: issue(1'b1, 1'b1, 16'($urandom_range(0, 255)), $urandom, 4'($urandom),
                       8'($urandom), 1'($urandom));
      endcase
    end
    drain();

    // Reset with responses still pending.
    for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 16'(i * 16), 32'h0, 4'h0, 8'(i + 20), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.ram_rd_resp_valid), 64'd0);
    chk("midrst_ready", 64'(bus.ram_cmd_ready),     64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 chk("midrst_hold_valid", 64'(bus.ram_rd_resp_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_after_midrst", 64'(bus.ram_cmd_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_beat", 64'(bus.ram_rd_resp_valid), 64'd0);
    end
    @(posedge clk); #2;
    read_direct(16'h0010, 8'h30, 1'b1, mdl[4]);
    read_direct(16'h0040, 8'h31, 1'b0, mdl[16]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
